// File: rtl/systolic_skew_feeder_if.sv
// Slice-input / array-edge bundle for systolic_skew_feeder.
// SKEW_FEEDER_PERF_EN adds the o_bubble_cnt performance counter.
interface systolic_skew_feeder_if #(
  parameter int N  = 4,
  parameter int KW = 8
);
  logic              i_start;
  logic [KW-1:0]     i_k_len;
  logic              i_valid;
  logic              o_ready;
  logic [N*8-1:0]    i_a_vec;
  logic [N*8-1:0]    i_b_vec;
  logic [N*8-1:0]    o_a_edge;
  logic [N*8-1:0]    o_b_edge;
  logic              o_do_process;
  logic              o_busy;
  logic              o_done;
`ifdef SKEW_FEEDER_PERF_EN
  logic [15:0]       o_bubble_cnt;

  modport master (
    output i_start, i_k_len, i_valid, i_a_vec, i_b_vec,
    input  o_ready, o_a_edge, o_b_edge, o_do_process, o_busy, o_done, o_bubble_cnt
  );
  modport slave (
    input  i_start, i_k_len, i_valid, i_a_vec, i_b_vec,
    output o_ready, o_a_edge, o_b_edge, o_do_process, o_busy, o_done, o_bubble_cnt
  );
`else
  modport master (
    output i_start, i_k_len, i_valid, i_a_vec, i_b_vec,
    input  o_ready, o_a_edge, o_b_edge, o_do_process, o_busy, o_done
  );
  modport slave (
    input  i_start, i_k_len, i_valid, i_a_vec, i_b_vec,
    output o_ready, o_a_edge, o_b_edge, o_do_process, o_busy, o_done
  );
`endif
endinterface

// File: rtl/systolic_skew_feeder.sv
// Triangular-skew feeder and job sequencer for an N x N output-stationary int8 systolic array.
// Optional macro SKEW_FEEDER_PERF_EN adds a saturating LOAD bubble counter (o_bubble_cnt).
module systolic_skew_feeder #(
  parameter int N        = 4,
  parameter int KW       = 8,
  parameter int MULT_LAT = 1
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  systolic_skew_feeder_if.slave  bus
);
  // Drain time: last diagonal crosses 2*(N-1) hops, then multiplier and accumulate stages.
  localparam int F  = 2*(N-1) + MULT_LAT + 1;
  localparam int FW = $clog2(F + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] acc_q, acc_d;
  logic [FW-1:0] fl_q, fl_d;
  logic          ready_q, busy_q, done_q;
  logic          hs;

  assign hs = bus.i_valid & ready_q;

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    acc_d   = acc_q;
    fl_d    = fl_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          acc_d = '0;
          if (bus.i_k_len != '0) begin
            k_len_d = bus.i_k_len;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (hs) begin
          acc_d = acc_q + KW'(1);
          if (acc_q == k_len_q - KW'(1)) begin
            state_d = FLUSH;
            fl_d    = FW'(F - 1);
          end
        end
      end
      FLUSH: begin
        if (fl_q == '0) state_d = DONE;
        else            fl_d    = fl_q - FW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change cleanly with the state.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      k_len_q <= '0;
      acc_q   <= '0;
      fl_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      acc_q   <= acc_d;
      fl_q    <= fl_d;
      ready_q <= (state_d == LOAD);
      busy_q  <= (state_d == LOAD) || (state_d == FLUSH);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_do_process = busy_q;
  assign bus.o_done       = done_q;

  // Lane r is an (r+1)-deep shift chain; non-handshake cycles inject zeros.
  for (genvar r = 0; r < N; r++) begin : g_lane
    logic signed [7:0] a_sh_q [r+1];
    logic signed [7:0] b_sh_q [r+1];

    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        for (int s = 0; s <= r; s++) begin
          a_sh_q[s] <= '0;
          b_sh_q[s] <= '0;
        end
      end else begin
        a_sh_q[0] <= hs ? $signed(bus.i_a_vec[8*r +: 8]) : 8'sd0;
        b_sh_q[0] <= hs ? $signed(bus.i_b_vec[8*r +: 8]) : 8'sd0;
        for (int s = 1; s <= r; s++) begin
          a_sh_q[s] <= a_sh_q[s-1];
          b_sh_q[s] <= b_sh_q[s-1];
        end
      end
    end

    assign bus.o_a_edge[8*r +: 8] = a_sh_q[r];
    assign bus.o_b_edge[8*r +: 8] = b_sh_q[r];
  end

`ifdef SKEW_FEEDER_PERF_EN
  logic [15:0] bub_q, bub_d;

  always_comb begin
    bub_d = bub_q;
    if (state_q == IDLE && bus.i_start)                          bub_d = '0;
    else if (state_q == LOAD && !bus.i_valid && bub_q != 16'hFFFF) bub_d = bub_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) bub_q <= '0;
    else           bub_q <= bub_d;
  end

  assign bus.o_bubble_cnt = bub_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a behavioural PE array on its edges.
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int F  = 2*(N-1) + 1 + 1;

  typedef logic [N*8-1:0] vec_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.N(N), .KW(KW)) bus ();
  systolic_skew_feeder #(.N(N), .KW(KW), .MULT_LAT(1)) dut (
    .i_clk   (clk),
    .i_arst_n(arst_n),
    .bus     (bus.slave)
  );

  int A [4][3] = '{'{1, -1, 7}, '{2, -128, -3}, '{3, 127, 0}, '{4, 5, -128}};
  int B [3][4] = '{'{2, -1, 3, 127}, '{-128, 1, 4, -2}, '{-5, 6, -128, 1}};

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  logic rdy_now = 1'b0;
  vec_t ha [64];
  vec_t hb [64];

  // Behavioural output-stationary PE array, multiplier latency 1.
  int pa [N][N], pb [N][N], pp [N][N], acc [N][N];
  int ain, bin;
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          pa[r][c] <= 0; pb[r][c] <= 0; pp[r][c] <= 0; acc[r][c] <= 0;
        end
    end else begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          if (c == 0) ain = int'($signed(bus.o_a_edge[8*r +: 8]));
          else        ain = pa[r][c-1];
          if (r == 0) bin = int'($signed(bus.o_b_edge[8*c +: 8]));
          else        bin = pb[r-1][c];
          pa[r][c]  <= ain;
          pb[r][c]  <= bin;
          pp[r][c]  <= ain * bin;
          acc[r][c] <= bus.o_do_process ? acc[r][c] + pp[r][c] : 0;
        end
    end
  end

  function automatic vec_t acol(input int k);
    vec_t v;
    for (int r = 0; r < N; r++) v[8*r +: 8] = 8'(A[r][k]);
    return v;
  endfunction

  function automatic vec_t brow(input int k);
    vec_t v;
    for (int c = 0; c < N; c++) v[8*c +: 8] = 8'(B[k][c]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic e_rdy, input logic e_busy, input logic e_dp, input logic e_done);
    vec_t ea, eb;
    int idx;
    ha[cyc] = (bus.i_valid && rdy_now) ? bus.i_a_vec : '0;
    hb[cyc] = (bus.i_valid && rdy_now) ? bus.i_b_vec : '0;
    @(posedge clk); #1;
    cyc++;
    ea = '0; eb = '0;
    for (int r = 0; r < N; r++) begin
      idx = cyc - 1 - r;
      if (idx >= 0) begin
        ea[8*r +: 8] = ha[idx][8*r +: 8];
        eb[8*r +: 8] = hb[idx][8*r +: 8];
      end
    end
    chk("o_ready",      bus.o_ready,      e_rdy);
    chk("o_busy",       bus.o_busy,       e_busy);
    chk("o_do_process", bus.o_do_process, e_dp);
    chk("o_done",       bus.o_done,       e_done);
    chk("o_a_edge",     bus.o_a_edge,     ea);
    chk("o_b_edge",     bus.o_b_edge,     eb);
    rdy_now = e_rdy;
  endtask

  task automatic check_sums(input int kl);
    int ref_v;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ref_v = 0;
        for (int k = 0; k < kl; k++) ref_v += A[r][k] * B[k][c];
        chk($sformatf("pe_sum[%0d][%0d]", r, c), acc[r][c], ref_v);
      end
  endtask

  // vmask bit i is i_valid in LOAD cycle i+1; valid is held high with junk data elsewhere.
  task automatic run_job(input int kl, input logic [31:0] vmask, input bit hold, input int exp_bub);
    int L, na, dc, n;
    L = 0; na = 0;
    while (na < kl && L < 32) begin
      if (vmask[L]) na++;
      L++;
    end
    dc = (kl == 0) ? 1 : L + F + 1;
    na = 0; cyc = 0; rdy_now = 1'b0;
    for (int cur = 0; cur <= dc; cur++) begin
      n = cur + 1;
      bus.i_start = (cur == 0) || hold;
      bus.i_k_len = KW'(kl);
      if (cur >= 1 && cur <= L && vmask[cur-1]) begin
        bus.i_valid = 1'b1;
        bus.i_a_vec = acol(na);
        bus.i_b_vec = brow(na);
        na++;
      end else begin
        bus.i_valid = !(cur >= 1 && cur <= L);
        bus.i_a_vec = vec_t'($urandom);
        bus.i_b_vec = vec_t'($urandom);
      end
      step(n >= 1 && n <= L, kl > 0 && n >= 1 && n < dc, kl > 0 && n >= 1 && n < dc, n == dc);
      if (n == dc) check_sums(kl);
`ifdef SKEW_FEEDER_PERF_EN
      if (n >= dc) chk("o_bubble_cnt", bus.o_bubble_cnt, exp_bub);
`else
      if (n >= dc) chk("bubble_free_sums", acc[0][0] * 0 + exp_bub * 0 + int'(bus.o_done), int'(n == dc));
`endif
    end
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_k_len = '0;
    bus.i_valid = 1'b0;
    bus.i_a_vec = '0;
    bus.i_b_vec = '0;

    #1;
    chk("rst_o_ready",      bus.o_ready,      1'b0);
    chk("rst_o_busy",       bus.o_busy,       1'b0);
    chk("rst_o_do_process", bus.o_do_process, 1'b0);
    chk("rst_o_done",       bus.o_done,       1'b0);
    chk("rst_o_a_edge",     bus.o_a_edge,     '0);
    chk("rst_o_b_edge",     bus.o_b_edge,     '0);
    #11 arst_n = 1'b1;
    @(posedge clk); #1;

    // Baseline k=3; slice 0 A lanes {1,2,3,4} also exercises skew alignment.
    run_job(3, 32'hFFFF_FFFF, 1'b0, 0);
    // Bubbles: valid 1,0,0,1.
    run_job(2, 32'hFFFF_FFF9, 1'b0, 2);
    // i_start held through LOAD, FLUSH and DONE.
    run_job(3, 32'hFFFF_FFFF, 1'b1, 0);
    // Zero-length job.
    run_job(0, 32'hFFFF_FFFF, 1'b0, 0);

    // Reset during FLUSH.
    cyc = 0; rdy_now = 1'b0;
    bus.i_start = 1'b1; bus.i_k_len = KW'(2); bus.i_valid = 1'b1;
    bus.i_a_vec = acol(0); bus.i_b_vec = brow(0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    bus.i_start = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    bus.i_a_vec = acol(1); bus.i_b_vec = brow(1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    bus.i_valid = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    arst_n = 1'b0;
    #1;
    chk("arst_o_ready",      bus.o_ready,      1'b0);
    chk("arst_o_busy",       bus.o_busy,       1'b0);
    chk("arst_o_do_process", bus.o_do_process, 1'b0);
    chk("arst_o_done",       bus.o_done,       1'b0);
    chk("arst_o_a_edge",     bus.o_a_edge,     '0);
    chk("arst_o_b_edge",     bus.o_b_edge,     '0);
    @(posedge clk); @(posedge clk); #2;
    arst_n = 1'b1;
    cyc = 0; rdy_now = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Normal job after the aborted one.
    run_job(1, 32'hFFFF_FFFF, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
